bird_flight_controller: RTL and testbench

//  Game-level sequencer for the bird sprite: runs vertical physics on a divided game tick,

---
 rtl/bird_pkg.sv | 39 +++
 rtl/bird_btn_edge.sv | 74 +++++++
 rtl/bird_flight_controller.sv | 186 ++++++++++++++++++
 tb/tb_bird_flight_controller.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/bird_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : bird_pkg                                                      |
// | Description : Shared encodings and screen constants for the bird sprite     |
// |               sequencer, renderer and animation generator.                  |
// | Revision    : 1.0  initial release                                          |
// +-----------------------------------------------------------------------------+
package bird_pkg;

   // Game sequencer state encodings
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_FLY  = 2'd1;
   localparam logic [1:0] ST_DEAD = 2'd2;

   // Animation-select codes consumed by the animation generator
   localparam logic [1:0] ANIM_HOVER = 2'b00;
   localparam logic [1:0] ANIM_FLAP  = 2'b01;
   localparam logic [1:0] ANIM_FALL  = 2'b10;
   localparam logic [1:0] ANIM_DEAD  = 2'b11;

   // Screen rows
   localparam int Y_GROUND = 440;
   localparam int Y_START  = 240;

   // Signed add with an upper saturation limit; the 9-bit sum cannot wrap.
   function automatic logic signed [7:0] sat_add(
      input logic signed [7:0] v,
      input logic signed [7:0] inc,
      input logic signed [7:0] lim
   );
      logic signed [8:0] s;
      s = $signed({v[7], v}) + $signed({inc[7], inc});
      if (s > $signed({lim[7], lim}))
         return lim;
      return s[7:0];
   endfunction

endpackage : bird_pkg
`default_nettype wire

// File: rtl/bird_btn_edge.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : bird_btn_edge                                                 |
// | Description : Flap button conditioning: 2-FF synchronizer, optional         |
// |               debounce (BIRD_BTN_DEBOUNCE_EN) and a registered one-cycle    |
// |               rising-edge pulse. Pin-to-pulse latency is 3 clk, plus        |
// |               DEB_CYCLES when the debounce stage is compiled in.            |
// | Revision    : 1.0  initial release                                          |
// +-----------------------------------------------------------------------------+
module bird_btn_edge #(
   parameter int DEB_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst,
   input  logic flap_btn,
   output logic flap_edge
);

   logic r_sync1;
   logic r_sync2;
   logic r_prev;
   logic r_edge;
   logic w_level;

   // Synchronize the raw pin and register the rising edge of the conditioned level
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_prev  <= 1'b0;
         r_edge  <= 1'b0;
      end else begin
         r_sync1 <= flap_btn;
         r_sync2 <= r_sync1;
         r_prev  <= w_level;
         r_edge  <= w_level & ~r_prev;
      end
   end

`ifdef BIRD_BTN_DEBOUNCE_EN
   localparam int c_DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [c_DW-1:0] c_DEB_LAST = c_DW'(DEB_CYCLES - 1);

   logic            r_deb;
   logic [c_DW-1:0] r_deb_cnt;

   // Accept a new level only after it has differed from the current one for DEB_CYCLES clk in a row
   always_ff @(posedge clk) begin
      if (rst) begin
         r_deb     <= 1'b0;
         r_deb_cnt <= '0;
      end else if (r_sync2 == r_deb) begin
         r_deb_cnt <= '0;
      end else if (r_deb_cnt == c_DEB_LAST) begin
         r_deb     <= r_sync2;
         r_deb_cnt <= '0;
      end else begin
         r_deb_cnt <= r_deb_cnt + c_DW'(1);
      end
   end

   assign w_level = r_deb;
`else
   // Debounce compiled out: the synchronized level drives the edge detector directly
   // and the window length has no effect.
   if (DEB_CYCLES >= 0) begin : g_raw_level
      assign w_level = r_sync2;
   end
`endif

   assign flap_edge = r_edge;

endmodule : bird_btn_edge
`default_nettype wire

// File: rtl/bird_flight_controller.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : bird_flight_controller                                        |
// | Description : Game-level sequencer for the bird sprite. Divides clk into a  |
// |               physics tick, integrates vertical motion, converts flap       |
// |               presses into impulses, detects death and drives the 2-bit     |
// |               animation-select code. Optional button debounce is enabled    |
// |               with the BIRD_BTN_DEBOUNCE_EN macro.                          |
// | Revision    : 1.0  initial release                                          |
// +-----------------------------------------------------------------------------+
module bird_flight_controller #(
   parameter int TICK_DIV   = 833333,
   parameter int GRAVITY    = 1,
   parameter int FLAP_VEL   = 8,
   parameter int VMAX       = 10,
   parameter int Y_TOP      = 0,
   parameter int Y_GROUND   = bird_pkg::Y_GROUND,
   parameter int Y_START    = bird_pkg::Y_START,
   parameter int DEB_CYCLES = 500000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       flap_btn,
   input  logic       collide,
   output logic [9:0] bird_y,
   output logic [7:0] bird_vy,
   output logic [1:0] anim_sel,
   output logic       game_over,
   output logic       tick
);
   import bird_pkg::*;

   localparam int c_TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [c_TW-1:0]    c_TICK_LAST = c_TW'(TICK_DIV - 1);
   localparam logic signed [7:0]  c_FLAP_VY   = 8'(-FLAP_VEL);
   localparam logic signed [7:0]  c_GRAVITY   = 8'(GRAVITY);
   localparam logic signed [7:0]  c_VMAX      = 8'(VMAX);
   localparam logic [9:0]         c_Y_TOP     = 10'(Y_TOP);
   localparam logic [9:0]         c_Y_GROUND  = 10'(Y_GROUND);
   localparam logic [9:0]         c_Y_START   = 10'(Y_START);
   localparam logic signed [10:0] c_TOP_S     = 11'(Y_TOP);
   localparam logic signed [10:0] c_GROUND_S  = 11'(Y_GROUND);

   logic [c_TW-1:0]    r_tick_cnt;
   logic               r_tick;
   logic [1:0]         r_state;
   logic [9:0]         r_y;
   logic signed [7:0]  r_vy;
   logic               r_pend;
   logic [1:0]         r_anim;
   logic               r_game_over;

   logic               w_tick_now;
   logic               w_flap_edge;
   logic               w_impulse;
   logic signed [7:0]  w_vy_phys;
   logic signed [10:0] w_y_sum;
   logic [1:0]         w_state_n;
   logic [9:0]         w_y_n;
   logic signed [7:0]  w_vy_n;
   logic               w_pend_n;
   logic [1:0]         w_anim_n;
   logic               w_game_over_n;

   bird_btn_edge #(
      .DEB_CYCLES (DEB_CYCLES)
   ) u_btn (
      .clk       (clk),
      .rst       (rst),
      .flap_btn  (flap_btn),
      .flap_edge (w_flap_edge)
   );

   // The physics step is decided in the cycle the counter wraps
   assign w_tick_now = (r_tick_cnt == c_TICK_LAST);

   // Free-running tick divider; only reset stops it, never a game-state change
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tick_cnt <= '0;
         r_tick     <= 1'b0;
      end else begin
         r_tick     <= w_tick_now;
         r_tick_cnt <= w_tick_now ? '0 : r_tick_cnt + c_TW'(1);
      end
   end

   // State register: game state, kinematics, pending flap and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_y         <= c_Y_START;
         r_vy        <= '0;
         r_pend      <= 1'b0;
         r_anim      <= ANIM_HOVER;
         r_game_over <= 1'b0;
      end else begin
         r_state     <= w_state_n;
         r_y         <= w_y_n;
         r_vy        <= w_vy_n;
         r_pend      <= w_pend_n;
         r_anim      <= w_anim_n;
         r_game_over <= w_game_over_n;
      end
   end

   // Next-state and physics: collision beats a tick, a same-cycle edge is consumed by the tick
   always_comb begin
      w_state_n = r_state;
      w_y_n     = r_y;
      w_vy_n    = r_vy;
      w_pend_n  = r_pend;
      w_impulse = r_pend | w_flap_edge;
      w_vy_phys = w_impulse ? c_FLAP_VY : sat_add(r_vy, c_GRAVITY, c_VMAX);
      w_y_sum   = $signed({1'b0, r_y}) + $signed({{3{w_vy_phys[7]}}, w_vy_phys});

      case (r_state)
         ST_IDLE: begin
            w_y_n    = c_Y_START;
            w_vy_n   = '0;
            w_pend_n = 1'b0;
            if (start || w_flap_edge) begin
               w_state_n = ST_FLY;
               w_vy_n    = c_FLAP_VY;
            end
         end
         ST_FLY: begin
            if (collide) begin
               w_state_n = ST_DEAD;
            end else if (w_tick_now) begin
               w_pend_n = 1'b0;
               if (w_y_sum < c_TOP_S) begin
                  w_y_n  = c_Y_TOP;
                  w_vy_n = '0;
               end else if (w_y_sum >= c_GROUND_S) begin
                  w_y_n     = c_Y_GROUND;
                  w_vy_n    = '0;
                  w_state_n = ST_DEAD;
               end else begin
                  w_y_n  = w_y_sum[9:0];
                  w_vy_n = w_vy_phys;
               end
            end else if (w_flap_edge) begin
               w_pend_n = 1'b1;
            end
         end
         ST_DEAD: begin
            if (start) begin
               w_state_n = ST_IDLE;
               w_y_n     = c_Y_START;
               w_vy_n    = '0;
               w_pend_n  = 1'b0;
            end
         end
         default: begin
            w_state_n = ST_IDLE;
            w_y_n     = c_Y_START;
            w_vy_n    = '0;
            w_pend_n  = 1'b0;
         end
      endcase
   end

   // Output decode from the upcoming state and velocity so outputs register with them
   always_comb begin
      w_anim_n      = ANIM_HOVER;
      w_game_over_n = 1'b0;
      case (w_state_n)
         ST_FLY:  w_anim_n = w_vy_n[7] ? ANIM_FLAP : ANIM_FALL;
         ST_DEAD: begin
            w_anim_n      = ANIM_DEAD;
            w_game_over_n = 1'b1;
         end
         default: w_anim_n = ANIM_HOVER;
      endcase
   end

   assign bird_y    = r_y;
   assign bird_vy   = r_vy;
   assign anim_sel  = r_anim;
   assign game_over = r_game_over;
   assign tick      = r_tick;

endmodule : bird_flight_controller
`default_nettype wire

// File: tb/tb_bird_flight_controller.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : tb_bird_flight_controller                                     |
// | Description : Randomized self-checking bench for bird_flight_controller     |
// |               with a behavioural reference model (TICK_DIV=4,               |
// |               DEB_CYCLES=3). Honours BIRD_BTN_DEBOUNCE_EN.                  |
// | Revision    : 1.0  initial release                                          |
// +-----------------------------------------------------------------------------+
module tb_bird_flight_controller;

   localparam int TD       = 4;
   localparam int DEB      = 3;
   localparam int FLAP     = 8;
   localparam int VMAX     = 10;
   localparam int TOP      = 0;
   localparam int GROUND   = 440;
   localparam int START_Y  = 240;
   localparam int M_IDLE   = 0;
   localparam int M_FLY    = 1;
   localparam int M_DEAD   = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       flap_btn;
   logic       collide;
   logic [9:0] bird_y;
   logic [7:0] bird_vy;
   logic [1:0] anim_sel;
   logic       game_over;
   logic       tick;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state
   int m_st, m_y, m_vy, m_cyc;
   bit m_pend, m_tick;
   bit lv_hist [0:2];     // conditioned button level after the last three edges
   bit pin_prev, pin_prev2;
   bit deb_lvl;
   int deb_run;
   int n_ground, n_top, n_collide;

   always #5 clk = ~clk;

   bird_flight_controller #(
      .TICK_DIV   (TD),
      .DEB_CYCLES (DEB)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .flap_btn  (flap_btn),
      .collide   (collide),
      .bird_y    (bird_y),
      .bird_vy   (bird_vy),
      .anim_sel  (anim_sel),
      .game_over (game_over),
      .tick      (tick)
   );

   task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         if (n_fail <= 20)
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
      end
   endtask

   // One clock of the game rules applied to the inputs seen at this edge
   task automatic model_step(input bit r, input bit s, input bit b, input bit c);
      bit edge_now, tdec, imp, lv_new;
      int nv, ny;
      if (r) begin
         m_st = M_IDLE; m_y = START_Y; m_vy = 0; m_pend = 0; m_cyc = 0; m_tick = 0;
         lv_hist = '{0, 0, 0}; pin_prev = 0; pin_prev2 = 0; deb_lvl = 0; deb_run = 0;
         return;
      end
      edge_now = lv_hist[1] && !lv_hist[2];
      tdec     = (m_cyc % TD) == TD - 1;
      m_cyc++;
      m_tick   = tdec;

      case (m_st)
         M_IDLE: begin
            m_pend = 0; m_y = START_Y; m_vy = 0;
            if (s || edge_now) begin
               m_st = M_FLY; m_vy = -FLAP;
            end
         end
         M_FLY: begin
            if (c) begin
               m_st = M_DEAD; n_collide++;
            end else if (tdec) begin
               imp    = m_pend || edge_now;
               m_pend = 0;
               nv     = imp ? -FLAP : ((m_vy + 1 > VMAX) ? VMAX : m_vy + 1);
               ny     = m_y + nv;
               if (ny < TOP) begin
                  m_y = TOP; m_vy = 0; n_top++;
               end else if (ny >= GROUND) begin
                  m_y = GROUND; m_vy = 0; m_st = M_DEAD; n_ground++;
               end else begin
                  m_y = ny; m_vy = nv;
               end
            end else if (edge_now) begin
               m_pend = 1;
            end
         end
         default: begin
            if (s) begin
               m_st = M_IDLE; m_y = START_Y; m_vy = 0; m_pend = 0;
            end
         end
      endcase

`ifdef BIRD_BTN_DEBOUNCE_EN
      if (pin_prev2 != deb_lvl) begin
         deb_run++;
         if (deb_run == DEB) begin
            deb_lvl = pin_prev2; deb_run = 0;
         end
      end else begin
         deb_run = 0;
      end
      lv_new = deb_lvl;
`else
      lv_new = pin_prev;
`endif
      lv_hist[2] = lv_hist[1];
      lv_hist[1] = lv_hist[0];
      lv_hist[0] = lv_new;
      pin_prev2  = pin_prev;
      pin_prev   = b;
   endtask

   task automatic cycle(input bit r, input bit s, input bit b, input bit c);
      int exp_anim;
      rst = r; start = s; flap_btn = b; collide = c;
      @(posedge clk);
      model_step(r, s, b, c);
      #1;
      exp_anim = (m_st == M_FLY) ? ((m_vy < 0) ? 1 : 2) : ((m_st == M_DEAD) ? 3 : 0);
      check("bird_y",    bird_y,           m_y);
      check("bird_vy",   $signed(bird_vy), m_vy);
      check("anim_sel",  anim_sel,         exp_anim);
      check("game_over", game_over,        (m_st == M_DEAD) ? 1 : 0);
      check("tick",      tick,             m_tick);
      @(negedge clk);
   endtask

   initial begin
      bit b;
      int btn_left, p_flap, p_coll;
      rst = 1'b1; start = 1'b0; flap_btn = 1'b0; collide = 1'b0;
      n_ground = 0; n_top = 0; n_collide = 0;
      b = 0; btn_left = 0;
      @(negedge clk);
      cycle(1, 0, 0, 0);
      for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0);
      // short glitch while idle, then a clean start
      cycle(0, 0, 1, 0);
      cycle(0, 0, 1, 0);
      for (int i = 0; i < 8; i++) cycle(0, 0, 0, 0);

      for (int ep = 0; ep < 18; ep++) begin
         case (ep % 3)
            0:       begin p_flap = 0;  p_coll = 0; end
            1:       begin p_flap = 45; p_coll = 0; end
            default: begin p_flap = 6;  p_coll = 4; end
         endcase
         for (int k = 0; k < 400; k++) begin
            bit s, c, r;
            if (btn_left > 0) begin
               btn_left--;
               if (btn_left == 0) b = 0;
            end else if ($urandom_range(99) < p_flap) begin
               b = 1; btn_left = $urandom_range(1, 5);
            end
            s = ($urandom_range(99) < 3);
            c = ($urandom_range(999) < p_coll);
            r = ($urandom_range(999) < 2);
            if (k == 0) s = 1;
            cycle(r, s, b, c);
         end
      end

      // the random run must have exercised the boundary cases
      check("ground_reached", (n_ground > 0) ? 1 : 0, 1);
      check("top_clamped",    (n_top > 0) ? 1 : 0,    1);
      check("collided",       (n_collide > 0) ? 1 : 0, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_bird_flight_controller
`default_nettype wire
